// File: rtl/quad_decoder_if.sv
// Purpose : encoder-side signal bundle for quad_decoder (A/B in; direction, step, error, ready out).
// Latency : n/a (wiring only).
// Backpressure: none; step/err are single-cycle pulses that the consumer must sample every cycle.
// Ports   : a_in, b_in (async encoder channels), up_down, step, err, err_cnt[ERR_W], ready;
//           idx_in / idx_pulse only when QDEC_INDEX_EN is defined.
// Modports: master = encoder/consumer side, slave = decoder side.
interface quad_decoder_if #(
    parameter int ERR_W = 8
);
    logic             a_in;
    logic             b_in;
    logic             up_down;
    logic             step;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             ready;
`ifdef QDEC_INDEX_EN
    logic             idx_in;
    logic             idx_pulse;

    modport master (output a_in, b_in, idx_in,
                    input  up_down, step, err, err_cnt, ready, idx_pulse);
    modport slave  (input  a_in, b_in, idx_in,
                    output up_down, step, err, err_cnt, ready, idx_pulse);
`else
    modport master (output a_in, b_in,
                    input  up_down, step, err, err_cnt, ready);
    modport slave  (input  a_in, b_in,
                    output up_down, step, err, err_cnt, ready);
`endif
endinterface

// File: rtl/quad_decoder.sv
// Purpose : quadrature front end - 2-flop sync, per-channel glitch filter, Gray decode to step/dir/err.
// Latency : a stable input level first sampled at edge N gives step/err during the cycle after edge N+2+FILT_LEN.
// Backpressure: none; transitions faster than FILT_LEN cycles per channel are filtered out, never queued.
// Ports   : clk, reset_n (async active-low), bus (quad_decoder_if.slave: a_in, b_in -> up_down, step,
//           err, err_cnt, ready). Define QDEC_INDEX_EN to add idx_in/idx_pulse (index channel).
module quad_decoder #(
    parameter int FILT_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    quad_decoder_if.slave  bus
);
    localparam int FCNT_W = 4;
`ifdef QDEC_INDEX_EN
    localparam int NCH = 3;     // bit2 = index, bit1 = A, bit0 = B
`else
    localparam int NCH = 2;     // bit1 = A, bit0 = B
`endif

    typedef enum logic {S_INIT, S_TRACK} state_t;

    state_t              state_q, state_d;
    logic                load_init;
    logic [1:0]          init_cnt_q;
    logic [NCH-1:0]      raw;
    logic [NCH-1:0]      sync1_q, sync2_q;
    logic [NCH-1:0]      filt_q;
    logic [NCH-1:0]      prev_q;      // filt_q one edge late; decode compares the two
    logic [FCNT_W-1:0]   fcnt_q [NCH];
    logic [1:0]          ab_diff;
    logic                up_q, step_q, err_q;
    logic [ERR_W-1:0]    err_cnt_q;

`ifdef QDEC_INDEX_EN
    assign raw = {bus.idx_in, bus.a_in, bus.b_in};
`else
    assign raw = {bus.a_in, bus.b_in};
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT && init_cnt_q != 2'd2)
                init_cnt_q <= init_cnt_q + 2'd1;
        end
    end

    // Edges 1 and 2 after release fill the synchronisers; edge 3 seeds the filter.
    always_comb begin
        state_d   = state_q;
        load_init = 1'b0;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == 2'd2) begin
                    state_d   = S_TRACK;
                    load_init = 1'b1;
                end
            end
            S_TRACK: state_d = S_TRACK;
            default: state_d = S_INIT;
        endcase
    end

    // ---------------- Synchroniser + filter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int i = 0; i < NCH; i++) fcnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NCH; i++) begin
                if (load_init) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else if (state_q == S_TRACK) begin
                    if (sync2_q[i] == filt_q[i]) begin
                        fcnt_q[i] <= '0;                 // glitch rejected
                    end else if (fcnt_q[i] == FCNT_W'(FILT_LEN - 1)) begin
                        filt_q[i] <= sync2_q[i];         // FILT_LEN consecutive mismatches
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + FCNT_W'(1);
                    end
                end
            end
        end
    end

    // ---------------- Gray decode ----------------
    assign ab_diff = prev_q[1:0] ^ filt_q[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            up_q      <= 1'b1;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            if (load_init) begin
                // Seed prev with the same value as filt so the start position is not counted.
                prev_q <= sync2_q;
            end else if (state_q == S_TRACK) begin
                prev_q <= filt_q;
                case (ab_diff)
                    2'b01, 2'b10: begin
                        step_q <= 1'b1;
                        // Single-bit change: up exactly when old A differs from new B
                        // (00->01, 01->11, 11->10, 10->00).
                        up_q   <= prev_q[1] ^ filt_q[0];
                    end
                    2'b11: begin
                        err_q <= 1'b1;
                        if (err_cnt_q != '1)
                            err_cnt_q <= err_cnt_q + ERR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef QDEC_INDEX_EN
    logic idx_pulse_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_pulse_q <= 1'b0;
        end else begin
            idx_pulse_q <= (state_q == S_TRACK) && !load_init && !prev_q[2] && filt_q[2]
                           && (filt_q[1:0] == 2'b00);
        end
    end

    assign bus.idx_pulse = idx_pulse_q;
`endif

    assign bus.up_down = up_q;
    assign bus.step    = step_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.ready   = (state_q == S_TRACK);

endmodule

// File: tb/tb_quad_decoder.sv
// Purpose : self-checking bench for quad_decoder; expected pulses queued at stimulus, checked by a monitor.
// Latency : expects step/err FILT_LEN+2 clocks after the first sampling edge of a new level.
// Backpressure: none (DUT has no flow control).
module tb_quad_decoder;
    localparam int FILT_LEN = 3;
    localparam int ERR_W    = 8;

    typedef struct {
        logic       is_err;
        logic       up_down;
        logic [7:0] err_cnt;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t e;

    // model state
    logic [1:0]  cur_ab = 2'b00;
    logic        up_m = 1'b1;
    logic [7:0]  errcnt_m = 8'd0;
    logic [15:0] pos = 16'd0;     // position counter driven by step/up_down, like the downstream counter
    logic [15:0] pos_before;

    quad_decoder_if #(.ERR_W(ERR_W)) bus ();

    quad_decoder #(.FILT_LEN(FILT_LEN), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse the DUT presents must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && (bus.step || bus.err)) begin
            vectors++;
            if (bus.step && bus.err) begin
                miscompares++;
                $display("FAIL step_err_overlap: step=1 err=1 at cycle %0d, required never both", cyc);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: step=%0b err=%0b at cycle %0d, required none",
                         bus.step, bus.err, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err !== bus.err || e.up_down !== bus.up_down
                    || e.err_cnt !== bus.err_cnt || e.cyc != cyc) begin
                    miscompares++;
                    $display("FAIL pulse: got err=%0b up=%0b cnt=%0d cyc=%0d, required err=%0b up=%0b cnt=%0d cyc=%0d",
                             bus.err, bus.up_down, bus.err_cnt, cyc,
                             e.is_err, e.up_down, e.err_cnt, e.cyc);
                end
            end
            if (bus.step) pos = bus.up_down ? pos + 16'd1 : pos - 16'd1;
        end
    end

    task automatic do_reset(input logic [1:0] ab);
        @(posedge clk);
        #3;
        reset_n  = 1'b0;
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        #1;
        check("rst_up_down", int'(bus.up_down), 1);
        check("rst_step",    int'(bus.step),    0);
        check("rst_err",     int'(bus.err),     0);
        check("rst_err_cnt", int'(bus.err_cnt), 0);
        check("rst_ready",   int'(bus.ready),   0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_edge1", int'(bus.ready), 0);
        @(posedge clk); #1;
        check("ready_edge2", int'(bus.ready), 0);
        @(posedge clk); #1;
        check("ready_edge3", int'(bus.ready), 1);
        cur_ab   = ab;
        up_m     = 1'b1;
        errcnt_m = 8'd0;
    endtask

    // Drive a new A/B level right after an edge and hold it for 'hold' sampling edges.
    task automatic move(input logic [1:0] ab, input int hold);
        exp_t       x;
        logic [1:0] d;
        @(posedge clk);
        #1;
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        d = ab ^ cur_ab;
        x.cyc = cyc + 1 + FILT_LEN + 2;
        if (d == 2'b11) begin
            if (errcnt_m != 8'd255) errcnt_m = errcnt_m + 8'd1;
            x.is_err = 1'b1;
        end else if (d != 2'b00) begin
            case ({cur_ab, ab})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: up_m = 1'b1;
                default:                            up_m = 1'b0;
            endcase
            x.is_err = 1'b0;
        end
        x.up_down = up_m;
        x.err_cnt = errcnt_m;
        if (d != 2'b00) exp_q.push_back(x);
        cur_ab = ab;
        repeat (hold - 1) @(posedge clk);
    endtask

    initial begin
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
`ifdef QDEC_INDEX_EN
        bus.idx_in = 1'b0;
`endif
        // Start up at 11: no pulse in INIT; the first move proves filt_ab loaded as 11.
        do_reset(2'b11);
        repeat (10) @(posedge clk);
        move(2'b10, 10);
        move(2'b00, 10);

        // Forward: 4 up steps.
        move(2'b01, 10);
        move(2'b11, 10);
        move(2'b10, 10);
        move(2'b00, 10);
        #1;
        check("fwd_up_down", int'(bus.up_down), 1);
        check("fwd_err_cnt", int'(bus.err_cnt), 0);

        // Reverse: 4 down steps; direction held afterwards.
        pos_before = pos;
        move(2'b10, 10);
        move(2'b11, 10);
        move(2'b01, 10);
        move(2'b00, 10);
        repeat (10) @(posedge clk);
        #1;
        check("rev_up_down_held", int'(bus.up_down), 0);
        check("rev_pos_delta", int'(pos_before - pos), 4);

        // Glitch of 2 cycles on A: rejected, nothing queued.
        @(posedge clk); #1;
        bus.a_in = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus.a_in = 1'b0;
        repeat (12) @(posedge clk);
        // 3 cycles: accepted (00->10 down), then the return to 00 (up).
        move(2'b10, 3);
        move(2'b00, 12);

        // Illegal: 00->11 then 299 more double changes; count saturates at 255.
        move(2'b11, 12);
        #1;
        check("illegal_err_cnt1", int'(bus.err_cnt), 1);
        check("illegal_up_held",  int'(bus.up_down), 1);
        for (int i = 1; i < 300; i++) move(~cur_ab, 6);
        repeat (10) @(posedge clk);
        #1;
        check("err_cnt_sat", int'(bus.err_cnt), 255);

        // Reset with a filter count pending on the 00->01 move: no step from it or after release.
        @(posedge clk); #1;
        bus.b_in = 1'b1;
        repeat (3) @(posedge clk);
        do_reset(2'b01);
        repeat (20) @(posedge clk);
        move(2'b11, 12);
        #1;
        check("post_rst_up_down", int'(bus.up_down), 1);

        repeat (10) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
